// File: rtl/rvsteel_spi_sequencer.sv
// rvsteel_spi_sequencer: drives the rvsteel SPI controller register port
// through configure / select / per-byte TX-poll-RX / deselect sequences.
module rvsteel_spi_sequencer #(
  parameter int LEN_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [7:0]           cmd_cs,
  input  logic                 cmd_cpol,
  input  logic                 cmd_cpha,
  input  logic [7:0]           cmd_clock_div,
  input  logic [LEN_WIDTH-1:0] cmd_len,
  input  logic                 cmd_keep_cs,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [7:0]           tx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic [7:0]           rx_data,
  output logic                 busy,
  output logic                 done,
  output logic [4:0]           spi_rw_address,
  output logic [7:0]           spi_write_data,
  output logic [3:0]           spi_write_strobe,
  output logic                 spi_write_request,
  input  logic                 spi_write_response,
  output logic                 spi_read_request,
  input  logic [31:0]          spi_read_data,
  input  logic                 spi_read_response
);

  localparam logic [4:0] A_CPOL = 5'h00;
  localparam logic [4:0] A_CPHA = 5'h04;
  localparam logic [4:0] A_CS   = 5'h08;
  localparam logic [4:0] A_DIV  = 5'h0C;
  localparam logic [4:0] A_TX   = 5'h10;
  localparam logic [4:0] A_RX   = 5'h14;
  localparam logic [4:0] A_BUSY = 5'h18;

  typedef enum logic [3:0] {
    S_IDLE, S_CPOL, S_CPHA, S_DIV, S_CS,
    S_GET_TX, S_TX, S_HOLD, S_POLL, S_RX,
    S_PUSH, S_END, S_DONE
  } state_t;

  state_t               state;
  logic                 cpha_q;
  logic [7:0]           div_q;
  logic [7:0]           cs_q;
  logic                 keep_q;
  logic [LEN_WIDTH-1:0] remaining;
  logic                 hold_cnt;

  logic unused_read_bits;
  assign unused_read_bits = ^spi_read_data[31:8];

  // Strobe marks the single valid byte lane of a write.
  assign spi_write_strobe = {3'b000, spi_write_request};

  // Sequencer FSM; every bus request is a one-cycle registered pulse.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state             <= S_IDLE;
      cmd_ready         <= 1'b1;
      tx_ready          <= 1'b0;
      rx_valid          <= 1'b0;
      rx_data           <= 8'h00;
      busy              <= 1'b0;
      done              <= 1'b0;
      spi_rw_address    <= 5'h00;
      spi_write_data    <= 8'h00;
      spi_write_request <= 1'b0;
      spi_read_request  <= 1'b0;
      cpha_q            <= 1'b0;
      div_q             <= 8'h00;
      cs_q              <= 8'h00;
      keep_q            <= 1'b0;
      remaining         <= '0;
      hold_cnt          <= 1'b0;
    end else begin
      spi_write_request <= 1'b0;
      spi_read_request  <= 1'b0;
      done              <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cpha_q            <= cmd_cpha;
            div_q             <= cmd_clock_div;
            cs_q              <= cmd_cs;
            keep_q            <= cmd_keep_cs;
            remaining         <= cmd_len;
            cmd_ready         <= 1'b0;
            busy              <= 1'b1;
            state             <= S_CPOL;
            spi_rw_address    <= A_CPOL;
            spi_write_data    <= {7'b0, cmd_cpol};
            spi_write_request <= 1'b1;
          end
        end
        S_CPOL: begin
          if (spi_write_response) begin
            state             <= S_CPHA;
            spi_rw_address    <= A_CPHA;
            spi_write_data    <= {7'b0, cpha_q};
            spi_write_request <= 1'b1;
          end
        end
        S_CPHA: begin
          if (spi_write_response) begin
            state             <= S_DIV;
            spi_rw_address    <= A_DIV;
            spi_write_data    <= div_q;
            spi_write_request <= 1'b1;
          end
        end
        S_DIV: begin
          if (spi_write_response) begin
            state             <= S_CS;
            spi_rw_address    <= A_CS;
            spi_write_data    <= cs_q;
            spi_write_request <= 1'b1;
          end
        end
        S_CS: begin
          if (spi_write_response) begin
            if (remaining == '0) begin
              state <= S_END;
              if (!keep_q) begin
                spi_rw_address    <= A_CS;
                spi_write_data    <= 8'hFF;
                spi_write_request <= 1'b1;
              end
            end else begin
              state    <= S_GET_TX;
              tx_ready <= 1'b1;
            end
          end
        end
        S_GET_TX: begin
          if (tx_valid) begin
            tx_ready          <= 1'b0;
            state             <= S_TX;
            spi_rw_address    <= A_TX;
            spi_write_data    <= tx_data;
            spi_write_request <= 1'b1;
          end
        end
        S_TX: begin
          if (spi_write_response) begin
            state    <= S_HOLD;
            hold_cnt <= 1'b0;
          end
        end
        S_HOLD: begin
          if (hold_cnt) begin
            state            <= S_POLL;
            spi_rw_address   <= A_BUSY;
            spi_read_request <= 1'b1;
          end else begin
            hold_cnt <= 1'b1;
          end
        end
        S_POLL: begin
          if (spi_read_response) begin
            if (spi_read_data[0]) begin
              spi_read_request <= 1'b1;
            end else begin
              state            <= S_RX;
              spi_rw_address   <= A_RX;
              spi_read_request <= 1'b1;
            end
          end
        end
        S_RX: begin
          if (spi_read_response) begin
            rx_data  <= spi_read_data[7:0];
            rx_valid <= 1'b1;
            state    <= S_PUSH;
          end
        end
        S_PUSH: begin
          if (rx_ready) begin
            rx_valid  <= 1'b0;
            remaining <= remaining - 1'b1;
            if (remaining == LEN_WIDTH'(1)) begin
              state <= S_END;
              if (!keep_q) begin
                spi_rw_address    <= A_CS;
                spi_write_data    <= 8'hFF;
                spi_write_request <= 1'b1;
              end
            end else begin
              state    <= S_GET_TX;
              tx_ready <= 1'b1;
            end
          end
        end
        S_END: begin
          if (keep_q || spi_write_response) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          state     <= S_IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/rvsteel_spi_sequencer.md
Name: rvsteel_spi_sequencer

Overview:
Bus-master front end for the rvsteel SPI controller. It accepts one transaction command plus TX and RX byte streams and programs the controller's register port for the whole transfer: configure, select, send each byte, poll busy, read RX, deselect. It lets a DMA engine or hardware client run multi-byte SPI transfers without CPU involvement. It sits between the client and the SPI controller's IO interface; the controller is not shared.

Parameters:
LEN_WIDTH, 8, width of cmd_len; max transfer is 2^LEN_WIDTH-1 bytes.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer accepts command (high only in IDLE)
cmd_cs  in  8  chip-select index written to CHIP_SELECT
cmd_cpol  in  1  clock polarity
cmd_cpha  in  1  clock phase
cmd_clock_div  in  8  CLOCK_DIV value
cmd_len  in  LEN_WIDTH  byte count, 0 allowed
cmd_keep_cs  in  1  1 = leave CS asserted at end
tx_valid / tx_ready  in / out  1 / 1  TX byte handshake
tx_data  in  8  byte to send
rx_valid / rx_ready  out / in  1 / 1  RX byte handshake
rx_data  out  8  received byte
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse at transaction end
spi_rw_address  out  5  register address
spi_write_data  out  8  write data
spi_write_strobe  out  4  4'b0001 on writes, 0 otherwise
spi_write_request  out  1  write request
spi_write_response  in  1  write acknowledge
spi_read_request  out  1  read request
spi_read_data  in  32  read data, valid with spi_read_response
spi_read_response  in  1  read acknowledge

Behaviour:
- SPI register map: 0x00 CPOL, 0x04 CPHA, 0x08 CHIP_SELECT (0xFF = none), 0x0C CLOCK_DIV, 0x10 TX (write starts byte), 0x14 RX, 0x18 BUSY (bit0).
- Reset (reset==0 at clock edge): state IDLE; every output 0 except cmd_ready=1; spi_rw_address=0; rx_data=0. Reset mid-transaction aborts immediately. No deselect write is issued; the system reset also resets the controller.
- Bus access rule: request held exactly 1 cycle. The sequencer then waits (request low) until the matching response; it never has more than one access outstanding. Read data is captured on the spi_read_response cycle.
- Command latched on cmd_valid && cmd_ready; cmd_ready drops the next cycle.
- States, in order:
  - IDLE
  - W_CPOL (0x00 <- cpol), W_CPHA (0x04 <- cpha), W_DIV (0x0C <- div), W_CS (0x08 <- cs)
  - After W_CS: go to END if len==0, else GET_TX.
  - GET_TX: tx_ready=1; on tx_valid latch byte, go to W_TX.
  - W_TX: 0x10 <- byte.
  - HOLD: exactly 2 idle cycles after write response, covering controller start latency.
  - POLL: read 0x18; bit0=1 repeats POLL next cycle; bit0=0 goes to R_RX.
  - R_RX: read 0x14; rx_data <= read_data[7:0].
  - PUSH: rx_valid=1 until rx_ready; then decrement remaining. Nonzero goes to GET_TX, zero goes to END.
  - END: if keep_cs=0, write 0x08 <- 0xFF then DONE; otherwise go straight to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- tx_ready is high only in GET_TX; rx_valid only in PUSH. rx_data is stable while rx_valid.
- Remaining counter: LEN_WIDTH bits, loaded with cmd_len, no wrap. cmd_len=0 still configures and selects.
- Configuration writes are reissued every command, even if values are unchanged.
- Stalls on tx_valid, rx_ready or responses are unbounded; the sequencer holds state and has no timeout.

Test Plan:
- Single byte: cmd cs=0, cpol=0, cpha=0, div=2, len=1, keep_cs=0, tx 0xA5, slave echoes 0x3C. Writes appear in order 0x00=0, 0x04=0, 0x0C=2, 0x08=0, 0x10=0xA5, then BUSY polls, RX read, 0x08=0xFF. rx_data=0x3C; done pulses once; cmd_ready returns 1 the cycle after done.
- Burst: len=4, tx 01/02/03/04, keep_cs=1 on loopback. rx 01..04 in order, exactly 4 TX writes, no 0x08=0xFF write. Controller cs stays low after done.
- Backpressure: rx_ready held low 10 cycles, tx_valid gapped 5 cycles. No extra bus requests during stalls; rx_data stable; final data correct.
- len=0, keep_cs=0: exactly 5 writes (cpol, cpha, div, cs, 0xFF), no TX/RX accesses, tx_ready never high, done pulses.
- Slow responder: spi_write_response delayed 3 cycles. Each request stays a 1-cycle pulse and the next access waits for the response. BUSY read returning 1 three times yields 4 poll reads.
- Reset mid-burst: reset=0 during POLL of byte 2 of len=3. Next cycle busy=0, cmd_ready=1, all spi requests 0. A new command after release completes normally.
